// File: rtl/uart_move_rx_pkg.sv
// Shared state types and ASCII constants for the UART move-command receiver.
package uart_move_rx_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  typedef enum logic [1:0] {StWaitRow, StWaitCol, StWaitEnter} parse_state_e;

  localparam logic [7:0] AsciiZero  = 8'h30;
  localparam logic [7:0] AsciiSeven = 8'h37;
  localparam logic [7:0] AsciiCr    = 8'h0D;

  // True for the digits '0'..'7', the only legal row/column indices.
  function automatic logic is_index(logic [7:0] b);
    return (b >= AsciiZero) && (b <= AsciiSeven);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling FSM, framed byte output.
module uart_rx_byte
  import uart_move_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       RxD,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            rxd_meta_q, rxd_sync_q;
  logic            seen_high_q;

  // Sync flops clear low so a line held low out of reset never looks like an idle line.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rxd_meta_q  <= 1'b0;
      rxd_sync_q  <= 1'b0;
      seen_high_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rxd_meta_q  <= RxD;
      rxd_sync_q  <= rxd_meta_q;
      seen_high_q <= seen_high_q | rxd_sync_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (seen_high_q && !rxd_sync_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          state_d = rxd_sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullCnt) begin
          cnt_d     = '0;
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == FullCnt) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rxd_sync_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    rx_byte   = rx_byte_q;
    rx_valid  = rx_valid_q;
    frame_err = frame_err_q;
  end

endmodule

// File: rtl/uart_move_rx.sv
// Receives "<row><col><CR>" ASCII move commands over UART and commits one-hot Row/Col.
module uart_move_rx
  import uart_move_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       RxD,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [7:0] Row,
  output logic [7:0] Col,
  output logic       move_valid,
  output logic       cmd_err,
  output logic       busy
);

  parse_state_e pstate_q, pstate_d;
  logic [2:0]   row_idx_q, row_idx_d;
  logic [2:0]   col_idx_q, col_idx_d;
  logic [7:0]   row_q, row_d;
  logic [7:0]   col_q, col_d;
  logic         move_valid_q, move_valid_d;
  logic         cmd_err_q, cmd_err_d;
  logic         abort;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .Reset    (Reset),
    .RxD      (RxD),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      pstate_q     <= StWaitRow;
      row_idx_q    <= '0;
      col_idx_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      move_valid_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      pstate_q     <= pstate_d;
      row_idx_q    <= row_idx_d;
      col_idx_q    <= col_idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      move_valid_q <= move_valid_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  always_comb begin
    pstate_d     = pstate_q;
    row_idx_d    = row_idx_q;
    col_idx_d    = col_idx_q;
    row_d        = row_q;
    col_d        = col_q;
    move_valid_d = 1'b0;
    cmd_err_d    = 1'b0;
    abort        = 1'b0;
    if (rx_valid) begin
      case (pstate_q)
        StWaitRow: begin
          if (is_index(rx_byte)) begin
            row_idx_d = rx_byte[2:0];
            pstate_d  = StWaitCol;
          end
        end
        StWaitCol: begin
          if (is_index(rx_byte)) begin
            col_idx_d = rx_byte[2:0];
            pstate_d  = StWaitEnter;
          end else begin
            abort = 1'b1;
          end
        end
        StWaitEnter: begin
          if (rx_byte == AsciiCr) begin
            row_d        = 8'd1 << row_idx_q;
            col_d        = 8'd1 << col_idx_q;
            move_valid_d = 1'b1;
            row_idx_d    = '0;
            col_idx_d    = '0;
            pstate_d     = StWaitRow;
          end else begin
            abort = 1'b1;
          end
        end
        default: pstate_d = StWaitRow;
      endcase
    end else if (frame_err && (pstate_q != StWaitRow)) begin
      abort = 1'b1;
    end
    // A broken command restarts from scratch; a bad frame before any digit is just noise.
    if (abort) begin
      cmd_err_d = 1'b1;
      row_idx_d = '0;
      col_idx_d = '0;
      pstate_d  = StWaitRow;
    end
  end

  always_comb begin
    Row        = row_q;
    Col        = col_q;
    move_valid = move_valid_q;
    cmd_err    = cmd_err_q;
  end

endmodule

// File: tb/tb_uart_move_rx.sv
// Self-checking bench for uart_move_rx: vector table, random commands vs. model, corner cases.
module tb_uart_move_rx;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       Reset;
  logic       RxD;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic [7:0] Row;
  logic [7:0] Col;
  logic       move_valid;
  logic       cmd_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_move_rx #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .RxD       (RxD),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .Row       (Row),
    .Col       (Col),
    .move_valid(move_valid),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;
  int n_rxv = 0, n_fe = 0, n_mv = 0, n_ce = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse counting and cycle-level invariants, sampled away from the active edge.
  logic       prev_rxv = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_rst = 1'b0;
  logic [7:0] prev_row = 8'h00, prev_col = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) n_rxv++;
    if (frame_err) n_fe++;
    if (cmd_err) n_ce++;
    if (rx_valid || frame_err) chk("rxv_fe_exclusive", {31'b0, rx_valid & frame_err}, 0);
    if (move_valid) begin
      n_mv++;
      chk("mv_one_cycle_after_cr", {23'b0, prev_rxv, prev_byte}, 32'h10D);
      chk("row_onehot", {31'b0, $onehot(Row)}, 1);
      chk("col_onehot", {31'b0, $onehot(Col)}, 1);
    end
    if ((Row !== prev_row || Col !== prev_col) && !prev_rst)
      chk("rowcol_change_only_on_move", {31'b0, move_valid}, 1);
    prev_rxv  = rx_valid;
    prev_byte = rx_byte;
    prev_rst  = Reset;
    prev_row  = Row;
    prev_col  = Col;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RxD = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      tick(Cpb);
    end
    RxD = stop;
    tick(Cpb);
    RxD = 1'b1;
    tick(Cpb);
  endtask

  // Reference model: a command is the list of characters accepted so far.
  logic [7:0] m_row, m_col, m_last;
  int         m_ce, m_mv;
  logic [7:0] pend[$];

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h37);
  endfunction

  task automatic model_byte(input logic [7:0] b, input logic ok);
    if (!ok) begin
      if (pend.size() != 0) m_ce++;
      pend.delete();
      return;
    end
    m_last = b;
    if (pend.size() == 0) begin
      if (is_digit(b)) pend.push_back(b);
    end else if (pend.size() == 1) begin
      if (is_digit(b)) pend.push_back(b);
      else begin
        m_ce++;
        pend.delete();
      end
    end else begin
      if (b == 8'h0D) begin
        m_row = 8'd1 << (pend[0] - 8'h30);
        m_col = 8'd1 << (pend[1] - 8'h30);
        m_mv++;
      end else begin
        m_ce++;
      end
      pend.delete();
    end
  endtask

  typedef struct packed {
    logic [0:3][7:0] b;
    logic [2:0]      n;
    logic [0:3]      stop;
    logic [7:0]      exp_row;
    logic [7:0]      exp_col;
    logic [7:0]      exp_last;
    logic [2:0]      d_rxv;
    logic [2:0]      d_fe;
    logic [2:0]      d_mv;
    logic [2:0]      d_ce;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int b_rxv, b_fe, b_mv, b_ce, k;
    logic busy_hi;
    logic [7:0] rb;
    logic rok;
    logic [7:0] four;

    vecs[0] = '{b: {8'h33, 8'h35, 8'h0D, 8'h00}, n: 3'd3, stop: 4'b1110, exp_row: 8'h08,
                exp_col: 8'h20, exp_last: 8'h0D, d_rxv: 3'd3, d_fe: 3'd0, d_mv: 3'd1, d_ce: 3'd0};
    vecs[1] = '{b: {8'h41, 8'h00, 8'h00, 8'h00}, n: 3'd1, stop: 4'b0000, exp_row: 8'h08,
                exp_col: 8'h20, exp_last: 8'h0D, d_rxv: 3'd0, d_fe: 3'd1, d_mv: 3'd0, d_ce: 3'd0};
    vecs[2] = '{b: {8'h32, 8'h39, 8'h00, 8'h00}, n: 3'd2, stop: 4'b1100, exp_row: 8'h08,
                exp_col: 8'h20, exp_last: 8'h39, d_rxv: 3'd2, d_fe: 3'd0, d_mv: 3'd0, d_ce: 3'd1};
    vecs[3] = '{b: {8'h31, 8'h31, 8'h0D, 8'h00}, n: 3'd3, stop: 4'b1110, exp_row: 8'h02,
                exp_col: 8'h02, exp_last: 8'h0D, d_rxv: 3'd3, d_fe: 3'd0, d_mv: 3'd1, d_ce: 3'd0};
    vecs[4] = '{b: {8'h0A, 8'h36, 8'h34, 8'h0D}, n: 3'd4, stop: 4'b1111, exp_row: 8'h40,
                exp_col: 8'h10, exp_last: 8'h0D, d_rxv: 3'd4, d_fe: 3'd0, d_mv: 3'd1, d_ce: 3'd0};
    vecs[5] = '{b: {8'h35, 8'h35, 8'h00, 8'h00}, n: 3'd2, stop: 4'b1000, exp_row: 8'h40,
                exp_col: 8'h10, exp_last: 8'h35, d_rxv: 3'd1, d_fe: 3'd1, d_mv: 3'd0, d_ce: 3'd1};
    vecs[6] = '{b: {8'h37, 8'h30, 8'h41, 8'h00}, n: 3'd3, stop: 4'b1110, exp_row: 8'h40,
                exp_col: 8'h10, exp_last: 8'h41, d_rxv: 3'd3, d_fe: 3'd0, d_mv: 3'd0, d_ce: 3'd1};
    vecs[7] = '{b: {8'h78, 8'h30, 8'h30, 8'h0D}, n: 3'd4, stop: 4'b1111, exp_row: 8'h01,
                exp_col: 8'h01, exp_last: 8'h0D, d_rxv: 3'd4, d_fe: 3'd0, d_mv: 3'd1, d_ce: 3'd0};

    // Reset state
    RxD   = 1'b1;
    Reset = 1'b1;
    tick(3);
    chk("reset_rx_byte", rx_byte, 8'h00);
    chk("reset_row", Row, 8'h00);
    chk("reset_col", Col, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {rx_valid, frame_err, move_valid, cmd_err}, 4'h0);
    Reset = 1'b0;
    tick(Cpb);

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      b_rxv = n_rxv; b_fe = n_fe; b_mv = n_mv; b_ce = n_ce;
      for (int j = 0; j < int'(vecs[v].n); j++) send_byte(vecs[v].b[j], vecs[v].stop[j]);
      tick(4);
      chk($sformatf("vec%0d_row", v), Row, vecs[v].exp_row);
      chk($sformatf("vec%0d_col", v), Col, vecs[v].exp_col);
      chk($sformatf("vec%0d_rx_byte", v), rx_byte, vecs[v].exp_last);
      chk($sformatf("vec%0d_rx_valid_count", v), n_rxv - b_rxv, vecs[v].d_rxv);
      chk($sformatf("vec%0d_frame_err_count", v), n_fe - b_fe, vecs[v].d_fe);
      chk($sformatf("vec%0d_move_valid_count", v), n_mv - b_mv, vecs[v].d_mv);
      chk($sformatf("vec%0d_cmd_err_count", v), n_ce - b_ce, vecs[v].d_ce);
    end

    // Randomized byte stream against the model
    m_row = 8'h01; m_col = 8'h01; m_last = 8'h0D; m_ce = 0; m_mv = 0;
    pend.delete();
    b_mv = n_mv; b_ce = n_ce;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 4) rb = 8'h30 + 8'($urandom_range(0, 7));
      else if (k <= 6) rb = 8'h0D;
      else if (k == 7) rb = 8'h0A;
      else if (k == 8) rb = 8'h38 + 8'($urandom_range(0, 1));
      else rb = 8'($urandom_range(0, 255));
      rok = ($urandom_range(0, 7) != 0);
      send_byte(rb, rok);
      model_byte(rb, rok);
      tick(2);
      chk($sformatf("rand%0d_row", i), Row, m_row);
      chk($sformatf("rand%0d_col", i), Col, m_col);
      chk($sformatf("rand%0d_rx_byte", i), rx_byte, m_last);
      chk($sformatf("rand%0d_cmd_err_count", i), n_ce - b_ce, m_ce);
      chk($sformatf("rand%0d_move_valid_count", i), n_mv - b_mv, m_mv);
    end

    // Short low glitch: start detected, then rejected with no pulse
    tick(Cpb);
    b_rxv = n_rxv; b_fe = n_fe;
    busy_hi = 1'b0;
    RxD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (busy) busy_hi = 1'b1;
    end
    RxD = 1'b1;
    k = 0;
    while (busy && k < 9) begin
      tick(1);
      k++;
    end
    chk("glitch_busy_seen", busy_hi, 1);
    chk("glitch_busy_cleared", busy, 0);
    tick(2 * Cpb);
    chk("glitch_rx_valid_count", n_rxv - b_rxv, 0);
    chk("glitch_frame_err_count", n_fe - b_fe, 0);

    // Reset in the middle of '4' (during bit 6): outputs clear, tail yields nothing
    four = 8'h34;
    RxD = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 6; i++) begin
      RxD = four[i];
      tick(Cpb);
    end
    RxD = four[6];
    tick(4);
    Reset = 1'b1;
    tick(1);
    chk("midreset_rx_byte", rx_byte, 8'h00);
    chk("midreset_row", Row, 8'h00);
    chk("midreset_col", Col, 8'h00);
    chk("midreset_busy", busy, 0);
    chk("midreset_pulses", {rx_valid, frame_err, move_valid, cmd_err}, 4'h0);
    Reset = 1'b0;
    b_rxv = n_rxv;
    tick(Cpb - 5);
    RxD = four[7];
    tick(Cpb);
    RxD = 1'b1;
    tick(4 * Cpb);
    chk("midreset_tail_rx_valid_count", n_rxv - b_rxv, 0);
    send_byte(8'h30, 1'b1);
    send_byte(8'h37, 1'b1);
    send_byte(8'h0D, 1'b1);
    tick(4);
    chk("after_reset_row", Row, 8'h01);
    chk("after_reset_col", Col, 8'h80);

    // Line held low through reset release: no start until it has gone high
    RxD = 1'b0;
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    busy_hi = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy) busy_hi = 1'b1;
    end
    chk("low_line_no_start", busy_hi, 0);
    RxD = 1'b1;
    tick(Cpb);
    b_rxv = n_rxv;
    send_byte(8'h36, 1'b1);
    tick(2);
    chk("low_line_then_byte", rx_byte, 8'h36);
    chk("low_line_rx_valid_count", n_rxv - b_rxv, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_move_rx.md
UART_MOVE_RX -- requirements
Module: uart_move_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (115200 baud at 100 MHz); legal values are 4 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single 100 MHz system clock; all logic runs on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port RxD, input, 1 bit: asynchronous UART serial line, 8N1 format, idle high.
REQ-005 The block SHALL have port rx_byte, output, 8 bits: the last correctly framed byte.
REQ-006 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_byte updates.
REQ-007 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-008 The block SHALL have port Row, output, 8 bits: one-hot committed row, in the same encoding as the Row switch bus.
REQ-009 The block SHALL have port Col, output, 8 bits: one-hot committed column, in the same encoding as the Col switch bus.
REQ-010 The block SHALL have port move_valid, output, 1 bit: one-cycle pulse when Row/Col commit.
REQ-011 The block SHALL have port cmd_err, output, 1 bit: one-cycle pulse when a command sequence is aborted.
REQ-012 The block SHALL have port busy, output, 1 bit: high while the receiver is outside IDLE.

Function
REQ-013 RxD SHALL pass through a two-flop synchronizer; all sampling uses the synchronized signal.
REQ-014 Receiver FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE: synced RxD=0 -> START, bit counter cleared.
- START: sample at count CLKS_PER_BIT/2-1; 0 -> DATA; 1 -> IDLE as a glitch, with no pulse.
- DATA: sample every CLKS_PER_BIT cycles, shifting LSB first; after the 8th bit -> STOP.
- STOP: sample after CLKS_PER_BIT cycles; 1 -> rx_valid with rx_byte, and 0 -> frame_err with rx_byte unchanged; both cases -> IDLE.
REQ-015 rx_valid or frame_err SHALL assert on the cycle after the stop-bit sample; the two are never asserted together.
REQ-016 After reset, IDLE SHALL ignore RxD until RxD has been sampled high at least once, so a line held low causes no false start.
REQ-017 Parser FSM states SHALL be WAIT_ROW, WAIT_COL, WAIT_ENTER, advanced only by rx_valid or frame_err.
- WAIT_ROW: byte 0x30-0x37 -> latch index r=byte-0x30, -> WAIT_COL.
- WAIT_COL: byte 0x30-0x37 -> latch index c, -> WAIT_ENTER.
- WAIT_ENTER: byte 0x0D -> Row<=1<<r, Col<=1<<c, move_valid pulse, -> WAIT_ROW.
REQ-018 In WAIT_COL and WAIT_ENTER, any other byte or a frame_err SHALL abort: cmd_err pulses, latched indices are discarded, and the parser returns to WAIT_ROW.
REQ-019 In WAIT_ROW, an invalid byte (including 0x0A) SHALL be silently ignored, with no cmd_err pulse.
REQ-020 move_valid SHALL assert exactly one cycle after the rx_valid of the 0x0D byte.
REQ-021 Row and Col SHALL hold their values between commits and always be one-hot or all-zero.
REQ-022 Row and Col SHALL update only on a move_valid cycle.

Reset
REQ-023 On Reset, both FSMs SHALL go to IDLE/WAIT_ROW.
REQ-024 On Reset, counters, shift register, rx_byte, Row, Col, latched indices and the seen-high flag SHALL clear to 0.
REQ-025 On Reset, all pulse outputs and busy SHALL be 0.
REQ-026 A reset asserted mid-frame or mid-command SHALL drop all partial data; a frame whose tail follows reset release SHALL be treated as new line activity.

Structure
REQ-027 A shared package SHALL hold the receiver and parser state enums and the ASCII constants 0x30, 0x37 and 0x0D.
REQ-028 The serial receiver SHALL be the sub-module uart_rx_byte, which owns the synchronizer, the receiver FSM, rx_byte, rx_valid, frame_err and busy.
REQ-029 The parser and the Row/Col registers SHALL live in uart_move_rx, which instantiates uart_rx_byte.

Verification (CLKS_PER_BIT=16)
REQ-030 Sending '3','5',0x0D -> three rx_valid pulses, then Row=0x08, Col=0x20 and one move_valid pulse 1 cycle after the last rx_valid.
REQ-031 Sending byte 0x41 with stop bit 0 -> frame_err pulse; rx_byte keeps its previous value; no rx_valid.
REQ-032 An 8-cycle low glitch on RxD -> no rx_valid, no frame_err, busy back to 0 within 9 cycles.
REQ-033 Sending '2','9' -> cmd_err pulse; Row/Col unchanged; a following '1','1',0x0D -> Row=0x02, Col=0x02.
REQ-034 Reset asserted during DATA of '4' -> all outputs 0 the next cycle; the remaining bits produce no rx_valid; a subsequent '0','7',0x0D -> Row=0x01, Col=0x80.
REQ-035 RxD held low through reset release for 100 cycles, then high -> no start is detected until RxD is high; a subsequent byte 0x36 is received correctly.
